// File: rtl/mos_half_adder_if.sv
// Operand/result bundle for the mos_half_adder block.
interface mos_half_adder_if;
    logic        bist_en;
    logic        a;
    logic        b;
    logic        in_valid;
    logic        sum;
    logic        cout;
    logic        out_valid;
    logic        a_mon;
    logic        b_mon;
    logic        err;
    logic [15:0] ops_cnt;

    modport master (
        output bist_en, a, b, in_valid,
        input  sum, cout, out_valid, a_mon, b_mon, err, ops_cnt
    );

    modport slave (
        input  bist_en, a, b, in_valid,
        output sum, cout, out_valid, a_mon, b_mon, err, ops_cnt
    );
endinterface

// File: rtl/mos_half_adder.sv
// Registered NAND-network half adder with a toggle self-test source,
// a behavioural cross-checker and a saturating result counter.
module mos_half_adder #(
    parameter int A_HALF_PERIOD = 10,
    parameter int B_HALF_PERIOD = 20
) (
    input logic             clk,
    input logic             rst,
    mos_half_adder_if.slave bus
);
    localparam int A_CW = (A_HALF_PERIOD > 1) ? $clog2(A_HALF_PERIOD) : 1;
    localparam int B_CW = (B_HALF_PERIOD > 1) ? $clog2(B_HALF_PERIOD) : 1;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [A_CW-1:0] a_cnt;
    logic [B_CW-1:0] b_cnt;
    logic            a_gen;
    logic            b_gen;

    logic a_p0, b_p0, vld_p0;
    logic w2, w4, w5, w7, w9;
    logic sum_p0, cout_p0, mismatch_p0;

    logic        sum_p1, cout_p1, a_mon_p1, b_mon_p1, vld_p1, err_p1;
    logic [15:0] ops_cnt_p1;

    // Self-test generator; held at phase 0 whenever the self-test is off
    always_ff @(posedge clk) begin
        if (rst || !bus.bist_en) begin
            a_cnt <= '0;
            b_cnt <= '0;
            a_gen <= 1'b0;
            b_gen <= 1'b0;
        end else begin
            if (a_cnt == A_CW'(A_HALF_PERIOD - 1)) begin
                a_cnt <= '0;
                a_gen <= ~a_gen;
            end else begin
                a_cnt <= a_cnt + A_CW'(1);
            end
            if (b_cnt == B_CW'(B_HALF_PERIOD - 1)) begin
                b_cnt <= '0;
                b_gen <= ~b_gen;
            end else begin
                b_cnt <= b_cnt + B_CW'(1);
            end
        end
    end

    // Stage p0: operand select, gate network and behavioural reference
    always_comb begin
        a_p0   = bus.bist_en ? a_gen : bus.a;
        b_p0   = bus.bist_en ? b_gen : bus.b;
        vld_p0 = bus.bist_en | bus.in_valid;

        w2      = ~a_p0;
        w5      = ~b_p0;
        w4      = ~(w2 & b_p0);
        w7      = ~(w5 & a_p0);
        sum_p0  = ~(w4 & w7);
        w9      = ~(a_p0 & b_p0);
        cout_p0 = ~w9;

        mismatch_p0 = (sum_p0 != (a_p0 ^ b_p0)) || (cout_p0 != (a_p0 & b_p0));
    end

    // Stage p1: registered results; payload holds on invalid cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_p1     <= 1'b0;
            cout_p1    <= 1'b0;
            a_mon_p1   <= 1'b0;
            b_mon_p1   <= 1'b0;
            vld_p1     <= 1'b0;
            err_p1     <= 1'b0;
            ops_cnt_p1 <= '0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                sum_p1     <= sum_p0;
                cout_p1    <= cout_p0;
                a_mon_p1   <= a_p0;
                b_mon_p1   <= b_p0;
                ops_cnt_p1 <= sat_inc(ops_cnt_p1);
                if (mismatch_p0)
                    err_p1 <= 1'b1;
            end
        end
    end

    assign bus.sum       = sum_p1;
    assign bus.cout      = cout_p1;
    assign bus.a_mon     = a_mon_p1;
    assign bus.b_mon     = b_mon_p1;
    assign bus.out_valid = vld_p1;
    assign bus.err       = err_p1;
    assign bus.ops_cnt   = ops_cnt_p1;
endmodule

// File: tb/tb_mos_half_adder.sv
// Directed bench for mos_half_adder: truth table, hold, self-test, reset and saturation.
module tb_mos_half_adder;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    mos_half_adder_if bus ();

    mos_half_adder #(.A_HALF_PERIOD(10), .B_HALF_PERIOD(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.bist_en = 1'b0; bus.a = 1'b1; bus.b = 1'b1; bus.in_valid = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
        end
        checks++;
        if ({bus.sum, bus.cout, bus.a_mon, bus.b_mon, bus.err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00000", {bus.sum, bus.cout, bus.a_mon, bus.b_mon, bus.err});
        end
        checks++;
        if (bus.ops_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_ops_cnt got=%0d exp=0", bus.ops_cnt);
        end
    endtask

    task automatic test_truth_table();
        logic [1:0] vec [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [1:0] res [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
        rst = 1'b0; bus.bist_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.a = vec[i][1]; bus.b = vec[i][0]; bus.in_valid = 1'b1;
            tick();
            checks++;
            if ({bus.out_valid, bus.sum, bus.cout, bus.a_mon, bus.b_mon} !== {1'b1, res[i], vec[i]}) begin
                failures++;
                $display("FAIL truth_%0d got vld,sum,cout,a,b=%b exp=%b", i,
                         {bus.out_valid, bus.sum, bus.cout, bus.a_mon, bus.b_mon}, {1'b1, res[i], vec[i]});
            end
            checks++;
            if (bus.ops_cnt !== 16'(i + 1)) begin
                failures++; $display("FAIL truth_ops_cnt_%0d got=%0d exp=%0d", i, bus.ops_cnt, i + 1);
            end
        end
    endtask

    task automatic test_hold();
        bus.in_valid = 1'b0; bus.a = 1'b0; bus.b = 1'b0;
        tick();
        checks++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.a_mon, bus.b_mon} !== 5'b00111) begin
            failures++;
            $display("FAIL hold got vld,sum,cout,a,b=%b exp=00111",
                     {bus.out_valid, bus.sum, bus.cout, bus.a_mon, bus.b_mon});
        end
        checks++;
        if (bus.ops_cnt !== 16'd4) begin
            failures++; $display("FAIL hold_ops_cnt got=%0d exp=4", bus.ops_cnt);
        end
    endtask

    // Runs n self-test cycles starting at generator phase 0 and checks every result.
    task automatic run_bist(input int n, input string tag, output logic [3:0] seen);
        logic ea, eb;
        seen = 4'b0;
        for (int k = 0; k < n; k++) begin
            ea = 1'((k / 10) % 2);
            eb = 1'((k / 20) % 2);
            tick();
            seen[{ea, eb}] = 1'b1;
            checks++;
            if ({bus.out_valid, bus.a_mon, bus.b_mon, bus.sum, bus.cout} !== {1'b1, ea, eb, ea ^ eb, ea & eb}) begin
                failures++;
                $display("FAIL %s_cycle_%0d got vld,a,b,sum,cout=%b exp=%b", tag, k,
                         {bus.out_valid, bus.a_mon, bus.b_mon, bus.sum, bus.cout},
                         {1'b1, ea, eb, ea ^ eb, ea & eb});
            end
        end
    endtask

    task automatic test_bist();
        logic [3:0] seen;
        rst = 1'b1; bus.bist_en = 1'b1; bus.in_valid = 1'b0; bus.a = 1'b1; bus.b = 1'b1;
        tick();
        rst = 1'b0;
        run_bist(40, "bist", seen);
        checks++;
        if (seen !== 4'b1111) begin
            failures++; $display("FAIL bist_combos got=%b exp=1111", seen);
        end
        checks++;
        if (bus.ops_cnt !== 16'd40) begin
            failures++; $display("FAIL bist_ops_cnt got=%0d exp=40", bus.ops_cnt);
        end
        checks++;
        if (bus.err !== 1'b0) begin
            failures++; $display("FAIL bist_err got=%b exp=0", bus.err);
        end
    endtask

    task automatic test_bist_reset();
        logic [3:0] seen;
        repeat (15) tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.a_mon, bus.b_mon, bus.err} !== 6'b0 || bus.ops_cnt !== 16'd0) begin
            failures++;
            $display("FAIL bist_reset got outs=%b ops=%0d exp=000000 ops=0",
                     {bus.out_valid, bus.sum, bus.cout, bus.a_mon, bus.b_mon, bus.err}, bus.ops_cnt);
        end
        rst = 1'b0;
        run_bist(12, "bist_restart", seen);
        checks++;
        if (bus.ops_cnt !== 16'd12) begin
            failures++; $display("FAIL bist_restart_ops_cnt got=%0d exp=12", bus.ops_cnt);
        end
    endtask

    task automatic test_bist_switch();
        bus.bist_en = 1'b0; bus.a = 1'b1; bus.b = 1'b1; bus.in_valid = 1'b1;
        tick();
        checks++;
        if ({bus.out_valid, bus.a_mon, bus.b_mon, bus.sum, bus.cout} !== 5'b11101) begin
            failures++;
            $display("FAIL switch_to_ext got vld,a,b,sum,cout=%b exp=11101",
                     {bus.out_valid, bus.a_mon, bus.b_mon, bus.sum, bus.cout});
        end
        bus.in_valid = 1'b0;
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.ops_cnt !== 16'd13) begin
            failures++; $display("FAIL switch_idle got vld=%b ops=%0d exp vld=0 ops=13", bus.out_valid, bus.ops_cnt);
        end
        bus.bist_en = 1'b1;
        tick();
        checks++;
        if ({bus.out_valid, bus.a_mon, bus.b_mon, bus.sum, bus.cout} !== 5'b10000) begin
            failures++;
            $display("FAIL switch_to_bist got vld,a,b,sum,cout=%b exp=10000",
                     {bus.out_valid, bus.a_mon, bus.b_mon, bus.sum, bus.cout});
        end
    endtask

    task automatic test_saturation();
        rst = 1'b1; bus.bist_en = 1'b0; bus.in_valid = 1'b0;
        tick();
        rst = 1'b0; bus.a = 1'b0; bus.b = 1'b1; bus.in_valid = 1'b1;
        repeat (65534) tick();
        checks++;
        if (bus.ops_cnt !== 16'hFFFE) begin
            failures++; $display("FAIL sat_pre got=%h exp=fffe", bus.ops_cnt);
        end
        tick();
        checks++;
        if (bus.ops_cnt !== 16'hFFFF) begin
            failures++; $display("FAIL sat_reach got=%h exp=ffff", bus.ops_cnt);
        end
        repeat (3) tick();
        checks++;
        if (bus.ops_cnt !== 16'hFFFF) begin
            failures++; $display("FAIL sat_hold got=%h exp=ffff", bus.ops_cnt);
        end
        checks++;
        if ({bus.out_valid, bus.sum, bus.cout, bus.err} !== 4'b1100) begin
            failures++;
            $display("FAIL sat_result got vld,sum,cout,err=%b exp=1100", {bus.out_valid, bus.sum, bus.cout, bus.err});
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_hold();
        test_bist();
        test_bist_reset();
        test_bist_switch();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mos_half_adder.md
MOS_HALF_ADDER -- requirements
Module: mos_half_adder

Interface
REQ-001 Parameter: A_HALF_PERIOD, default 10, number of clk cycles between self-test toggles of operand a.
REQ-002 Parameter: B_HALF_PERIOD, default 20, number of clk cycles between self-test toggles of operand b.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 bist_en  input  1  1 = internal toggle stimulus, 0 = external operands.
REQ-006 a  input  1  external operand a.
REQ-007 b  input  1  external operand b.
REQ-008 in_valid  input  1  external operands qualified this cycle (ignored when bist_en=1).
REQ-009 sum  output  1  registered half-adder sum.
REQ-010 cout  output  1  registered half-adder carry.
REQ-011 out_valid  output  1  sum/cout/a_mon/b_mon valid this cycle.
REQ-012 a_mon  output  1  operand a that produced the current result.
REQ-013 b_mon  output  1  operand b that produced the current result.
REQ-014 err  output  1  sticky mismatch flag from the internal checker.
REQ-015 ops_cnt  output  16  count of valid results produced since reset.

Function
REQ-016 Operand select: bist_en=0 -> (a, b, in_valid); bist_en=1 -> (a_gen, b_gen, 1).
REQ-017 Sum SHALL be computed combinationally as a NAND/inverter network: w2=~a, w5=~b, w4=NAND(w2,b), w7=NAND(w5,a), sum=NAND(w4,w7).
REQ-018 Carry SHALL be computed as w9=NAND(a,b), cout=~w9.
REQ-019 Latency: selected operands valid in cycle N -> sum, cout, a_mon, b_mon registered with out_valid=1 in cycle N+1.
REQ-020 Invalid cycle -> out_valid=0 next cycle; sum, cout, a_mon, b_mon hold previous values.
REQ-021 Self-test generator: cycle counters per operand; a_gen inverts when its counter reaches A_HALF_PERIOD-1 (counter wraps to 0); b_gen likewise with B_HALF_PERIOD.
REQ-022 While bist_en=0, a_gen, b_gen and both generator counters SHALL be held at 0; on bist_en rising they start from phase 0 (first a toggle after A_HALF_PERIOD cycles).
REQ-023 Checker: every valid cycle, network result compared with behavioural a XOR b and a AND b; any mismatch sets err=1 until reset.
REQ-024 ops_cnt increments by 1 per valid input cycle, saturates at 16'hFFFF (no wrap).
REQ-025 bist_en change mid-operation takes effect for operand selection in the same cycle; no output glitch or extra result generated.

Reset
REQ-026 rst=1 at a rising edge SHALL clear sum, cout, out_valid, a_mon, b_mon, err, ops_cnt, a_gen, b_gen and generator counters to 0.
REQ-027 rst has priority over in_valid and bist_en in the same cycle; no result is produced for inputs present during reset.
REQ-028 Reset asserted mid-operation discards any in-flight result; first valid result follows first valid cycle after rst deasserts.

Verification
REQ-029 Truth table, bist_en=0, in_valid=1: (a,b)=(0,0)->(sum,cout)=(0,0); (0,1)->(1,0); (1,0)->(1,0); (1,1)->(0,1); each one cycle later with out_valid=1.
REQ-030 in_valid=0 after (1,1) -> out_valid=0, sum=0, cout=1 held; ops_cnt unchanged.
REQ-031 bist_en=1 from reset, defaults -> a_mon toggles every 10 cycles, b_mon every 20; over 40 cycles all four input combinations appear, sum/cout match truth table, err stays 0, ops_cnt=40.
REQ-032 rst pulsed during bist run -> all outputs 0 next cycle; generator phase restarts at 0.
REQ-033 ops_cnt saturation: preload via 65535+ valid cycles -> ops_cnt stays 16'hFFFF.
REQ-034 rst and in_valid=1 same cycle -> out_valid=0 next cycle, ops_cnt=0.
